// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Instruction fetch stage feeding the IF/ID pipeline register. Owns the
//   fetch PC, keeps at most one word request outstanding on the instruction
//   memory req/gnt/rvalid handshake, parks a returned word in a skid register
//   when decode is stalled, and presents {pc, instr, valid} downstream with a
//   NOP bubble whenever nothing valid is available. Execute may redirect the
//   fetch stream at any time; a response still in flight is then dropped.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   REQ   | request at fa_q is offered whenever the output slot is free
//   WAIT  | one request granted, waiting for its rvalid
//   HOLD  | returned word parked in the skid register behind a stall
//
// Ports
//   clk, rstn       clock (rising edge), async active-low reset
//   i_stall         decode stall; presented instruction is held
//   i_redirect      flush and redirect from execute
//   i_redirect_pc   redirect target, bits [1:0] ignored
//   o_imem_req      memory request valid
//   o_imem_addr     word-aligned request address (always driven)
//   i_imem_gnt      request accepted this cycle
//   i_imem_rvalid   response valid, one per granted request
//   i_imem_rdata    response instruction word
//   o_pc            PC of presented instruction
//   o_instr         presented instruction, NOP_INSTR when not valid
//   o_valid         o_pc/o_instr hold a real instruction
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] rq_pc_q, rq_pc_d;
  logic        drop_q, drop_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic        slot_free;
  logic        req_fire;
  logic [31:0] redirect_target;

  // The output register can take a new word if it is empty or is being
  // consumed by decode at this edge.
  assign slot_free       = !out_valid_q || !i_stall;
  assign req_fire        = (state_q == ST_REQ) && slot_free && i_imem_gnt;
  assign redirect_target = {i_redirect_pc[31:2], 2'b00};

  assign o_imem_req  = (state_q == ST_REQ) && slot_free;
  assign o_imem_addr = fa_q;
  assign o_valid     = out_valid_q;
  assign o_pc        = out_pc_q;
  assign o_instr     = out_valid_q ? out_instr_q : NOP_INSTR;

  always_comb begin
    state_d      = state_q;
    fa_d         = fa_q;
    rq_pc_d      = rq_pc_q;
    drop_d       = drop_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (i_redirect) begin
      // Redirect wins over stall and every normal transition. Leaving HOLD
      // for REQ is what discards the skid contents.
      fa_d        = redirect_target;
      out_valid_d = 1'b0;
      case (state_q)
        ST_REQ: begin
          if (req_fire) begin
            // The word being granted now belongs to the old stream.
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_imem_rvalid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        ST_HOLD: state_d = ST_REQ;
        default: state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (!i_stall) out_valid_d = 1'b0;
          if (req_fire) begin
            rq_pc_d = fa_q;
            fa_d    = fa_q + 32'd4;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_stall) out_valid_d = 1'b0;
          if (i_imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else if (slot_free) begin
              out_valid_d = 1'b1;
              out_pc_d    = rq_pc_q;
              out_instr_d = i_imem_rdata;
              state_d     = ST_REQ;
            end else begin
              skid_pc_d    = rq_pc_q;
              skid_instr_d = i_imem_rdata;
              state_d      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!i_stall) begin
            out_valid_d = 1'b1;
            out_pc_d    = skid_pc_q;
            out_instr_d = skid_instr_q;
            state_d     = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_REQ;
      fa_q         <= RESET_PC;
      rq_pc_q      <= 32'h0;
      drop_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'h0;
      out_instr_q  <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      fa_q         <= fa_d;
      rq_pc_q      <= rq_pc_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Memory may only answer while a request is outstanding; any other rvalid
  // is ignored by the logic above and flagged here.
  a_rvalid_only_in_wait: assert property (@(posedge clk) disable iff (!rstn)
    i_imem_rvalid |-> (state_q == ST_WAIT))
    else $error("if_fetch: rvalid while no request outstanding");

endmodule
